gpu_blitter: RTL and testbench

Second-generation 2D blitter for the GPU. Accepts draw and clear commands over a valid/ready handshake, fetches sprite pixels from memory through a request/valid port with arbitrary latency, and writes pixels into the framebuffer one at a time. Extends the first-generation block with parametrised framebuffer geometry and widths, signed destination coordinates with screen clipping, horizontal/vertical flip, and colour-key transparency. Sits between the CPU-side GPU register file and the framebuffer write port.

---
 rtl/gpu_blitter_if.sv | 47 ++++
 rtl/gpu_blitter.sv | 150 +++++++++++++++
 tb/tb_gpu_blitter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_blitter_if.sv
// Blitter bus bundle: command handshake, sprite-memory read port and framebuffer write port.
// The blitter takes the slave side; the command/memory environment takes the master side.
interface gpu_blitter_if #(
   parameter int ADDR_W  = 32,
   parameter int COLOR_W = 16,
   parameter int COORD_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [ADDR_W-1:0]  cmd_address;
   logic [15:0]        cmd_src_x;
   logic [15:0]        cmd_src_y;
   logic [15:0]        cmd_sheet_w;
   logic [15:0]        cmd_width;
   logic [15:0]        cmd_height;
   logic [15:0]        cmd_x;
   logic [15:0]        cmd_y;
   logic               cmd_flip_x;
   logic               cmd_flip_y;
   logic               cmd_key_en;
   logic [COLOR_W-1:0] cmd_key_color;
   logic [COLOR_W-1:0] cmd_color;
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_valid;
   logic [COLOR_W-1:0] mem_rdata;
   logic               fb_write;
   logic [COORD_W-1:0] fb_x;
   logic [COORD_W-1:0] fb_y;
   logic [COLOR_W-1:0] fb_color;
   logic               busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_address, cmd_src_x, cmd_src_y, cmd_sheet_w,
             cmd_width, cmd_height, cmd_x, cmd_y, cmd_flip_x, cmd_flip_y,
             cmd_key_en, cmd_key_color, cmd_color, mem_valid, mem_rdata,
      output cmd_ready, mem_req, mem_addr, fb_write, fb_x, fb_y, fb_color, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_address, cmd_src_x, cmd_src_y, cmd_sheet_w,
             cmd_width, cmd_height, cmd_x, cmd_y, cmd_flip_x, cmd_flip_y,
             cmd_key_en, cmd_key_color, cmd_color, mem_valid, mem_rdata,
      input  cmd_ready, mem_req, mem_addr, fb_write, fb_x, fb_y, fb_color, busy
   );
endinterface

// File: rtl/gpu_blitter.sv
// 2D blitter: full-screen clear and sprite draw with signed-destination clipping,
// horizontal/vertical flip and colour-key transparency, one framebuffer pixel per write.
module gpu_blitter #(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int COORD_W   = 8,
   parameter int ADDR_W    = 32,
   parameter int COLOR_W   = 16
) (
   input  logic         clk,
   input  logic         rstn,
   gpu_blitter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CLEAR, DRAW_FETCH, DRAW_WRITE} state_t;
   state_t state;

   logic [ADDR_W-1:0]  r_address;
   logic [15:0]        r_src_x, r_src_y, r_sheet_w, r_width, r_height, r_x, r_y;
   logic               r_flip_x, r_flip_y, r_key_en;
   logic [COLOR_W-1:0] r_key_color;
   logic [15:0]        u, v;

   logic [ADDR_W-1:0]  g_address;
   logic [15:0]        g_src_x, g_src_y, g_sheet_w, g_width, g_height, g_x, g_y;
   logic               g_flip_x, g_flip_y;
   logic [15:0]        n_u, n_v, off_x, off_y;
   logic [16:0]        dx_n, dy_n, sx_n, sy_n;
   logic [33:0]        row_n;
   logic [ADDR_W-1:0]  addr_n;
   logic               vis_n, last, load_n;

   // Geometry is always evaluated for the *next* pixel so mem_req/mem_addr can be
   // registered one cycle ahead: from the live command on accept, else from (u,v)+1.
   always_comb begin
      if (state == IDLE) begin
         g_address = bus.cmd_address;  g_src_x  = bus.cmd_src_x;  g_src_y  = bus.cmd_src_y;
         g_sheet_w = bus.cmd_sheet_w;  g_width  = bus.cmd_width;  g_height = bus.cmd_height;
         g_x       = bus.cmd_x;        g_y      = bus.cmd_y;
         g_flip_x  = bus.cmd_flip_x;   g_flip_y = bus.cmd_flip_y;
         n_u       = '0;               n_v      = '0;
      end else begin
         g_address = r_address;  g_src_x  = r_src_x;  g_src_y  = r_src_y;
         g_sheet_w = r_sheet_w;  g_width  = r_width;  g_height = r_height;
         g_x       = r_x;        g_y      = r_y;
         g_flip_x  = r_flip_x;   g_flip_y = r_flip_y;
         if (u == r_width - 16'd1) begin
            n_u = '0;
            n_v = v + 16'd1;
         end else begin
            n_u = u + 16'd1;
            n_v = v;
         end
      end
      off_x  = g_flip_x ? g_width  - 16'd1 - n_u : n_u;
      off_y  = g_flip_y ? g_height - 16'd1 - n_v : n_v;
      sx_n   = {1'b0, g_src_x} + {1'b0, off_x};
      sy_n   = {1'b0, g_src_y} + {1'b0, off_y};
      row_n  = 34'(sy_n) * 34'(g_sheet_w);
      addr_n = g_address + ADDR_W'(row_n) + ADDR_W'(sx_n);
      dx_n   = {g_x[15], g_x} + {1'b0, n_u};
      dy_n   = {g_y[15], g_y} + {1'b0, n_v};
      vis_n  = !dx_n[16] && (dx_n[15:0] < 16'(FB_WIDTH)) &&
               !dy_n[16] && (dy_n[15:0] < 16'(FB_HEIGHT));
   end

   assign last   = (u == r_width - 16'd1) && (v == r_height - 16'd1);
   assign load_n = (state == IDLE && bus.cmd_valid && bus.cmd_op == 2'd0 &&
                    bus.cmd_width != 16'd0 && bus.cmd_height != 16'd0) ||
                   (state == DRAW_FETCH && !bus.mem_req && !last) ||
                   (state == DRAW_WRITE && !last);

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);

   // NOTE: only control state and the visible outputs are reset; the latched command,
   // pixel counters and mem_addr are always written before they are used.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         bus.mem_req  <= 1'b0;
         bus.fb_write <= 1'b0;
         bus.fb_x     <= '0;
         bus.fb_y     <= '0;
         bus.fb_color <= '0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               r_address   <= bus.cmd_address;  r_src_x  <= bus.cmd_src_x;
               r_src_y     <= bus.cmd_src_y;    r_sheet_w <= bus.cmd_sheet_w;
               r_width     <= bus.cmd_width;    r_height <= bus.cmd_height;
               r_x         <= bus.cmd_x;        r_y      <= bus.cmd_y;
               r_flip_x    <= bus.cmd_flip_x;   r_flip_y <= bus.cmd_flip_y;
               r_key_en    <= bus.cmd_key_en;   r_key_color <= bus.cmd_key_color;
               case (bus.cmd_op)
                  2'd0: if (load_n) state <= DRAW_FETCH;
                  2'd1: begin
                     state        <= CLEAR;
                     bus.fb_write <= 1'b1;
                     bus.fb_x     <= '0;
                     bus.fb_y     <= '0;
                     bus.fb_color <= bus.cmd_color;
                  end
                  default: ;
               endcase
            end
            CLEAR: begin
               if (bus.fb_x == COORD_W'(FB_WIDTH - 1)) begin
                  bus.fb_x <= '0;
                  if (bus.fb_y == COORD_W'(FB_HEIGHT - 1)) begin
                     bus.fb_y     <= '0;
                     bus.fb_write <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     bus.fb_y <= bus.fb_y + COORD_W'(1);
                  end
               end else begin
                  bus.fb_x <= bus.fb_x + COORD_W'(1);
               end
            end
            DRAW_FETCH: begin
               if (!bus.mem_req) begin
                  if (last) state <= IDLE;
               end else if (bus.mem_valid) begin
                  bus.mem_req  <= 1'b0;
                  bus.fb_color <= bus.mem_rdata;
                  bus.fb_write <= !(r_key_en && bus.mem_rdata == r_key_color);
                  state        <= DRAW_WRITE;
               end
            end
            DRAW_WRITE: begin
               bus.fb_write <= 1'b0;
               state        <= last ? IDLE : DRAW_FETCH;
            end
            default: state <= IDLE;
         endcase

         // Step to the next pixel; clipped pixels get mem_req low and cost one cycle.
         if (load_n) begin
            u            <= n_u;
            v            <= n_v;
            bus.mem_req  <= vis_n;
            bus.mem_addr <= addr_n;
            if (vis_n) begin
               bus.fb_x <= COORD_W'(dx_n);
               bus.fb_y <= COORD_W'(dy_n);
            end
         end
      end
   end
endmodule

// File: tb/tb_gpu_blitter.sv
// Scoreboard bench for gpu_blitter: expected memory reads and framebuffer writes are
// queued from a reference model when commands are issued and popped as the DUT responds.
module tb_gpu_blitter;
   localparam int FB_WIDTH = 160, FB_HEIGHT = 120, COORD_W = 8, ADDR_W = 32, COLOR_W = 16;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   gpu_blitter_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .COORD_W(COORD_W)) bus ();

   gpu_blitter #(
      .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .COORD_W(COORD_W),
      .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [15:0] src_x, src_y, sheet_w, w, h, x, y;
      logic        fx, fy, key_en;
      logic [15:0] key, color;
   } cmd_t;

   int n_checks = 0, n_fail = 0, n_writes = 0, n_reqs = 0;
   logic [63:0] exp_w[$];
   logic [63:0] exp_a[$];
   bit   mem_en = 1'b1;
   bit   inject_valid = 1'b0;
   int   mem_lat = 0, mem_mode = 0, wcnt = 0;
   bit   req_prev = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_data(input logic [31:0] a);
      return (mem_mode == 0) ? a[15:0] : (a[0] ? 16'hFFFF : 16'h0000);
   endfunction

   // Memory responder plus read/write monitors, all sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_en) begin
         bus.mem_valid = 1'b0;
         if (bus.mem_req) begin
            if (wcnt == mem_lat) begin
               bus.mem_valid = 1'b1;
               bus.mem_rdata = mem_data(bus.mem_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end else begin
         bus.mem_valid = inject_valid;
      end

      if (bus.mem_req) begin
         if (!req_prev) begin
            n_reqs++;
            if (exp_a.size() == 0) check("mem_unexpected_req", 64'(bus.mem_req), 64'd0);
            else check("mem_addr", 64'(bus.mem_addr), exp_a.pop_front());
            req_addr = bus.mem_addr;
         end else begin
            check("mem_addr_stable", 64'(bus.mem_addr), 64'(req_addr));
         end
      end
      req_prev = bus.mem_req;

      if (bus.fb_write) begin
         n_writes++;
         if (exp_w.size() == 0) check("fb_unexpected_write", 64'(bus.fb_write), 64'd0);
         else check("fb_pixel", {32'd0, bus.fb_x, bus.fb_y, bus.fb_color}, exp_w.pop_front());
      end
   end

   task automatic expect_draw(input cmd_t c);
      for (int v = 0; v < int'(c.h); v++) begin
         for (int u = 0; u < int'(c.w); u++) begin
            int dx, dy;
            logic [31:0] a, sx, sy;
            logic [15:0] d;
            dx = int'($signed(c.x)) + u;
            dy = int'($signed(c.y)) + v;
            if (dx >= 0 && dx < FB_WIDTH && dy >= 0 && dy < FB_HEIGHT) begin
               sx = 32'(c.src_x) + 32'(c.fx ? int'(c.w) - 1 - u : u);
               sy = 32'(c.src_y) + 32'(c.fy ? int'(c.h) - 1 - v : v);
               a  = c.addr + sy * 32'(c.sheet_w) + sx;
               exp_a.push_back(64'(a));
               d = mem_data(a);
               if (!(c.key_en && d == c.key)) exp_w.push_back({32'd0, dx[7:0], dy[7:0], d});
            end
         end
      end
   endtask

   // Offers a command and returns at the falling edge of the cycle after acceptance.
   task automatic send(input cmd_t c);
      int i;
      @(negedge clk);
      bus.cmd_op = c.op;         bus.cmd_address = c.addr;
      bus.cmd_src_x = c.src_x;   bus.cmd_src_y = c.src_y;   bus.cmd_sheet_w = c.sheet_w;
      bus.cmd_width = c.w;       bus.cmd_height = c.h;
      bus.cmd_x = c.x;           bus.cmd_y = c.y;
      bus.cmd_flip_x = c.fx;     bus.cmd_flip_y = c.fy;
      bus.cmd_key_en = c.key_en; bus.cmd_key_color = c.key;     bus.cmd_color = c.color;
      bus.cmd_valid = 1'b1;
      i = 0;
      while (!bus.cmd_ready && i < 100) begin
         @(negedge clk);
         i++;
      end
      check("cmd_ready_at_offer", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max, output int cycles);
      cycles = 0;
      while (bus.busy && cycles < max) begin
         cycles++;
         @(negedge clk);
      end
      check("idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_writes_left"}, 64'(exp_w.size()), 64'd0);
      check({tag, "_reads_left"}, 64'(exp_a.size()), 64'd0);
   endtask

   initial begin
      cmd_t c, base_c;
      int cyc, w0, r0;

      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_address = '0;
      bus.cmd_src_x = '0; bus.cmd_src_y = '0; bus.cmd_sheet_w = '0;
      bus.cmd_width = '0; bus.cmd_height = '0; bus.cmd_x = '0; bus.cmd_y = '0;
      bus.cmd_flip_x = 1'b0; bus.cmd_flip_y = 1'b0; bus.cmd_key_en = 1'b0;
      bus.cmd_key_color = '0; bus.cmd_color = '0;
      bus.mem_valid = 1'b0; bus.mem_rdata = '0;

      base_c = '{op: 2'd0, addr: 32'd100, src_x: 16'd2, src_y: 16'd1, sheet_w: 16'd8,
                 w: 16'd4, h: 16'd2, x: 16'd10, y: 16'd20, fx: 1'b0, fy: 1'b0,
                 key_en: 1'b0, key: 16'd0, color: 16'd0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_fb_write", 64'(bus.fb_write), 64'd0);
      check("rst_fb_xy", {48'd0, bus.fb_x, bus.fb_y}, 64'd0);
      check("rst_fb_color", 64'(bus.fb_color), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      rstn = 1'b1;

      // Full-screen clear
      for (int y = 0; y < FB_HEIGHT; y++)
         for (int x = 0; x < FB_WIDTH; x++)
            exp_w.push_back({32'd0, 8'(x), 8'(y), 16'hF800});
      c = base_c; c.op = 2'd1; c.color = 16'hF800;
      w0 = n_writes;
      send(c);
      check("clear_first_write_t1", 64'(bus.fb_write), 64'd1);
      wait_idle(30000, cyc);
      check("clear_busy_cycles", 64'(cyc), 64'd19200);
      check("clear_write_count", 64'(n_writes - w0), 64'd19200);
      check_drained("clear");

      // Plain draw, zero-wait memory
      mem_mode = 0; mem_lat = 0;
      c = base_c;
      expect_draw(c);
      w0 = n_writes;
      send(c);
      check("draw_first_req_t1", 64'(bus.mem_req), 64'd1);
      check("draw_first_addr", 64'(bus.mem_addr), 64'd110);
      wait_idle(200, cyc);
      check("draw_write_count", 64'(n_writes - w0), 64'd8);
      check("draw_cycles", 64'(cyc), 64'd16);
      check_drained("draw");

      // Flipped draw, 3-cycle memory latency
      mem_lat = 3;
      c = base_c; c.fx = 1'b1; c.fy = 1'b1;
      expect_draw(c);
      send(c);
      wait_idle(200, cyc);
      check_drained("flip");

      // Clipped draw at (-2,118)
      mem_lat = 1;
      c = base_c; c.w = 16'd4; c.h = 16'd4; c.x = 16'hFFFE; c.y = 16'd118;
      c.addr = 32'd0; c.src_x = 16'd0; c.src_y = 16'd0;
      expect_draw(c);
      w0 = n_writes; r0 = n_reqs;
      send(c);
      wait_idle(200, cyc);
      check("clip_write_count", 64'(n_writes - w0), 64'd4);
      check("clip_req_count", 64'(n_reqs - r0), 64'd4);
      check_drained("clip");

      // Colour key on, then off, over an alternating 0/FFFF sheet
      mem_mode = 1; mem_lat = 0;
      c = base_c; c.addr = 32'd0; c.src_x = 16'd0; c.src_y = 16'd0;
      c.x = 16'd30; c.y = 16'd30; c.key_en = 1'b1; c.key = 16'h0000;
      expect_draw(c);
      w0 = n_writes;
      send(c);
      wait_idle(200, cyc);
      check("key_on_write_count", 64'(n_writes - w0), 64'd4);
      check_drained("key_on");
      c.key_en = 1'b0;
      expect_draw(c);
      w0 = n_writes;
      send(c);
      wait_idle(200, cyc);
      check("key_off_write_count", 64'(n_writes - w0), 64'd8);
      check_drained("key_off");

      // Discarded opcode
      c = base_c; c.op = 2'd3;
      w0 = n_writes; r0 = n_reqs;
      send(c);
      check("op3_ready_next", 64'(bus.cmd_ready), 64'd1);
      repeat (4) @(negedge clk);
      check("op3_no_activity", 64'(n_writes - w0 + n_reqs - r0), 64'd0);

      // Reset while a read is outstanding, then a late mem_valid
      mem_mode = 0; mem_en = 1'b0;
      c = base_c;
      expect_draw(c);
      send(c);
      @(negedge clk);
      check("abort_req_pending", 64'(bus.mem_req), 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      check("abort_mem_req", 64'(bus.mem_req), 64'd0);
      check("abort_fb_write", 64'(bus.fb_write), 64'd0);
      check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      rstn = 1'b1;
      exp_w.delete();
      exp_a.delete();
      w0 = n_writes; r0 = n_reqs;
      inject_valid = 1'b1;
      repeat (2) @(negedge clk);
      inject_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("late_valid_no_write", 64'(n_writes - w0), 64'd0);
      mem_en = 1'b1;

      // Zero-width draw
      c = base_c; c.w = 16'd0;
      send(c);
      check("zero_w_ready_next", 64'(bus.cmd_ready), 64'd1);
      repeat (4) @(negedge clk);
      check("zero_w_no_activity", 64'(n_writes - w0 + n_reqs - r0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
